stream_period_checker: RTL and testbench

- Receive end of the sample stream (data_valid/data) produced by the periodic table-driven data source in the coherent-average bench.
- Captures the first M-sample frame after a start pulse, then checks that the next N_FRAMES-1 frames repeat it sample for sample.
- Reports pass/fail, a mismatch count and the first mismatch location. The captured frame can be read back.
- Used as a bench-side sink and self-checker ahead of, or alongside, the coherent averager.

---
 rtl/stream_period_checker_pkg.sv | 33 +++
 rtl/stream_period_checker_if.sv | 16 +
 rtl/stream_frame_ram.sv | 47 ++++
 rtl/stream_period_checker.sv | 148 ++++++++++++++
 tb/tb_stream_period_checker.sv | 243 ++++++++++++++++++++++++
 5 files changed

// File: rtl/stream_period_checker_pkg.sv
// -----------------------------------------------------------------------------
// stream_period_checker_pkg
// Shared types and constants for the stream period checker.
//   state_t  : FSM state encoding (IDLE=0, CAPTURE=1, COMPARE=2, DONE=3)
//   CNT_W    : width of mismatch and frame counters
//   CNT_MAX  : saturation value of the mismatch counter
//   clog2()  : address-width helper usable in parameter expressions
// -----------------------------------------------------------------------------
package stream_period_checker_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        COMPARE = 2'd2,
        DONE    = 2'd3
    } state_t;

    localparam int              CNT_W   = 16;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    // Ceiling log2, minimum 1 bit so a one-entry memory still has an address.
    function automatic int clog2(input int value);
        int w;
        w = 1;
        for (int i = 1; i < 32; i++) begin
            if ((1 << w) < value) begin
                w = w + 1;
            end
        end
        return w;
    endfunction

endpackage

// File: rtl/stream_period_checker_if.sv
// -----------------------------------------------------------------------------
// stream_period_checker_if
// Sample stream carried from the data source to the checker.
//   data_valid : one sample per cycle while high
//   data       : Q-bit sample value
// Modports: master (source side, drives), slave (checker side, receives).
// -----------------------------------------------------------------------------
interface stream_period_checker_if #(
    parameter int Q = 12
);
    logic         data_valid;
    logic [Q-1:0] data;

    modport master (output data_valid, output data);
    modport slave  (input  data_valid, input  data);
endinterface

// File: rtl/stream_frame_ram.sv
// -----------------------------------------------------------------------------
// stream_frame_ram
// M x Q frame buffer with one write port and two read ports.
//   clk, reset_n : clock and synchronous active-low reset (readback register only)
//   we/waddr/wdata : write port
//   cmp_addr/cmp_data : asynchronous read, used for same-cycle comparison
//   rd_addr/rd_data   : registered readback port, one-cycle latency; a read of
//                       the address being written returns the old contents
// -----------------------------------------------------------------------------
module stream_frame_ram #(
    parameter int M  = 32,
    parameter int Q  = 12,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [Q-1:0]  wdata,
    input  logic [AW-1:0] cmp_addr,
    output logic [Q-1:0]  cmp_data,
    input  logic [AW-1:0] rd_addr,
    output logic [Q-1:0]  rd_data
);

    logic [Q-1:0] mem [M];

    // NOTE: the storage array has no reset; only the readback register does.
    // Clearing a RAM would need M cycles or a flop array, and the contents are
    // always written by a capture before they are compared.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign cmp_data = mem[cmp_addr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            rd_data <= '0;
        end else begin
            rd_data <= mem[rd_addr];
        end
    end

endmodule

// File: rtl/stream_period_checker.sv
// -----------------------------------------------------------------------------
// stream_period_checker
// Captures the first M-sample frame after start, then checks that the next
// N_FRAMES-1 frames repeat it sample for sample.
//   clk, reset_n     : clock, synchronous active-low reset
//   start            : one-cycle pulse arming a run (honoured in IDLE/DONE only)
//   s_if (slave)     : sample stream (data_valid, data)
//   rd_addr/rd_data  : registered readback of the captured frame
//   busy             : run in progress (CAPTURE or COMPARE)
//   done             : run finished, held until next start or reset
//   pass             : valid while done, 1 when no sample mismatched
//   mismatch_count   : mismatching samples, saturating at 0xFFFF
//   first_bad_index  : sample index of the first mismatch
//   first_bad_frame  : frame number (1..N_FRAMES-1) of the first mismatch
// -----------------------------------------------------------------------------
module stream_period_checker
    import stream_period_checker_pkg::*;
#(
    parameter int M        = 32,
    parameter int Q        = 12,
    parameter int N_FRAMES = 4,
    localparam int AW      = clog2(M)
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    stream_period_checker_if.slave  s_if,
    input  logic [AW-1:0]           rd_addr,
    output logic [Q-1:0]            rd_data,
    output logic                    busy,
    output logic                    done,
    output logic                    pass,
    output logic [CNT_W-1:0]        mismatch_count,
    output logic [AW-1:0]           first_bad_index,
    output logic [CNT_W-1:0]        first_bad_frame
);

    state_t           state_q, state_d;
    logic [AW-1:0]    idx_q;
    logic [CNT_W-1:0] frame_q;
    logic [CNT_W-1:0] count_d;
    logic [Q-1:0]     cmp_data;
    logic             beat;
    logic             last_idx;
    logic             last_frame;
    logic             mismatch;
    logic             accept_start;

    stream_frame_ram #(
        .M  (M),
        .Q  (Q),
        .AW (AW)
    ) u_ram (
        .clk      (clk),
        .reset_n  (reset_n),
        .we       (state_q == CAPTURE && s_if.data_valid),
        .waddr    (idx_q),
        .wdata    (s_if.data),
        .cmp_addr (idx_q),
        .cmp_data (cmp_data),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data)
    );

    assign busy = (state_q == CAPTURE) || (state_q == COMPARE);
    assign done = (state_q == DONE);

    // NOTE: every signal written here gets its default first, so no path
    // through the case can leave one unassigned and infer a latch.
    always_comb begin
        state_d      = state_q;
        accept_start = 1'b0;
        beat         = busy && s_if.data_valid;
        last_idx     = (idx_q == AW'(M - 1));
        last_frame   = (frame_q == CNT_W'(N_FRAMES - 1));
        mismatch     = (state_q == COMPARE) && s_if.data_valid && (s_if.data != cmp_data);
        count_d      = mismatch_count;
        if (mismatch && mismatch_count != CNT_MAX) begin
            count_d = mismatch_count + 1'b1;
        end

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    accept_start = 1'b1;
                    state_d      = CAPTURE;
                end
            end
            CAPTURE: begin
                if (beat && last_idx) begin
                    state_d = COMPARE;
                end
            end
            COMPARE: begin
                if (beat && last_idx && last_frame) begin
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            idx_q           <= '0;
            frame_q         <= '0;
            mismatch_count  <= '0;
            first_bad_index <= '0;
            first_bad_frame <= '0;
            pass            <= 1'b0;
        end else begin
            state_q <= state_d;
            if (accept_start) begin
                // A start beat never carries a sample, even with data_valid high.
                idx_q           <= '0;
                frame_q         <= '0;
                mismatch_count  <= '0;
                first_bad_index <= '0;
                first_bad_frame <= '0;
                pass            <= 1'b0;
            end else if (beat) begin
                if (last_idx) begin
                    idx_q   <= '0;
                    frame_q <= frame_q + 1'b1;
                end else begin
                    idx_q <= idx_q + 1'b1;
                end
                if (state_q == COMPARE) begin
                    mismatch_count <= count_d;
                    // A zero count means no earlier mismatch in this run; the
                    // counter saturates, so it never wraps back to zero.
                    if (mismatch && mismatch_count == '0) begin
                        first_bad_index <= idx_q;
                        first_bad_frame <= frame_q;
                    end
                    // pass rises with done and includes the final beat's result.
                    if (last_idx && last_frame) begin
                        pass <= (count_d == '0);
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_stream_period_checker.sv
// -----------------------------------------------------------------------------
// tb_stream_period_checker
// Drives frames into stream_period_checker; expected results are computed from
// the driven frames, pushed to a scoreboard queue when a run is driven, and
// popped when the checker reports done.
// -----------------------------------------------------------------------------
module tb_stream_period_checker;
    import stream_period_checker_pkg::*;

    localparam int M  = 32;
    localparam int Q  = 12;
    localparam int NF = 4;
    localparam int AW = 5;

    typedef struct {
        bit pass;
        int cnt;
        int fbi;
        int fbf;
    } exp_t;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             start;
    logic [AW-1:0]    rd_addr;
    logic [Q-1:0]     rd_data;
    logic             busy;
    logic             done;
    logic             pass;
    logic [CNT_W-1:0] mismatch_count;
    logic [AW-1:0]    first_bad_index;
    logic [CNT_W-1:0] first_bad_frame;

    logic [Q-1:0] stim [NF][M];
    exp_t         sb [$];
    int           n_cmp = 0;
    int           n_bad = 0;

    stream_period_checker_if #(.Q(Q)) s_if ();

    stream_period_checker #(
        .M        (M),
        .Q        (Q),
        .N_FRAMES (NF)
    ) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .s_if            (s_if),
        .rd_addr         (rd_addr),
        .rd_data         (rd_data),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .mismatch_count  (mismatch_count),
        .first_bad_index (first_bad_index),
        .first_bad_frame (first_bad_frame)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ramp();
        for (int f = 0; f < NF; f++)
            for (int i = 0; i < M; i++)
                stim[f][i] = Q'(i);
    endtask

    function automatic exp_t model();
        exp_t e;
        e.cnt = 0;
        e.fbi = 0;
        e.fbf = 0;
        for (int f = 1; f < NF; f++)
            for (int i = 0; i < M; i++)
                if (stim[f][i] != stim[0][i]) begin
                    if (e.cnt == 0) begin
                        e.fbi = i;
                        e.fbf = f;
                    end
                    e.cnt++;
                end
        e.pass = (e.cnt == 0);
        return e;
    endfunction

    // One full run. gap: idle cycle before each beat. mid_start: pulse start
    // during COMPARE. pre_junk: valid beats before start and on the start cycle.
    task automatic drive_run(input string name, input bit gap, input bit mid_start, input bit pre_junk);
        exp_t e;
        int   waited;
        sb.push_back(model());
        if (pre_junk) begin
            for (int k = 0; k < 4; k++) begin
                s_if.data_valid = 1'b1;
                s_if.data       = 12'h555;
                tick();
            end
        end
        start           = 1'b1;
        s_if.data_valid = pre_junk;
        s_if.data       = 12'hABC;
        tick();
        start           = 1'b0;
        s_if.data_valid = 1'b0;
        check({name, "_busy_start"}, busy, 1);
        check({name, "_done_clr"}, done, 0);
        for (int f = 0; f < NF; f++) begin
            for (int i = 0; i < M; i++) begin
                if (gap) begin
                    s_if.data_valid = 1'b0;
                    tick();
                end
                s_if.data_valid = 1'b1;
                s_if.data       = stim[f][i];
                start           = mid_start && (f == 2) && (i == 3);
                tick();
                start = 1'b0;
            end
        end
        s_if.data_valid = 1'b0;
        waited = 0;
        while (!done && waited < 16) begin
            tick();
            waited++;
        end
        check({name, "_done_latency"}, waited, 0);
        check({name, "_sb_nonempty"}, sb.size() != 0, 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({name, "_pass"}, pass, e.pass);
            check({name, "_count"}, mismatch_count, e.cnt);
            check({name, "_bad_index"}, first_bad_index, e.fbi);
            check({name, "_bad_frame"}, first_bad_frame, e.fbf);
            check({name, "_busy_end"}, busy, 0);
        end
    endtask

    initial begin
        reset_n         = 1'b0;
        start           = 1'b0;
        rd_addr         = '0;
        s_if.data_valid = 1'b0;
        s_if.data       = '0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_count", mismatch_count, 0);
        check("rst_rd_data", rd_data, 0);
        reset_n = 1'b1;
        tick();

        // Clean ramp, continuous valid.
        load_ramp();
        drive_run("ramp", 1'b0, 1'b0, 1'b0);

        // Readback of the captured frame.
        rd_addr = 5'd7;
        tick();
        check("rd_7", rd_data, 12'h007);
        rd_addr = 5'd31;
        tick();
        check("rd_31", rd_data, 12'h01F);

        // Single corrupted sample.
        load_ramp();
        stim[2][5] = 12'h0FF;
        drive_run("one_bad", 1'b0, 1'b0, 1'b0);

        // Valid toggled every other cycle.
        load_ramp();
        drive_run("gapped", 1'b1, 1'b0, 1'b0);

        // start pulsed mid-COMPARE is ignored.
        load_ramp();
        drive_run("mid_start", 1'b0, 1'b1, 1'b0);

        // Beats before start, and on the start cycle, are not captured.
        load_ramp();
        drive_run("pre_junk", 1'b0, 1'b0, 1'b1);

        // Frame 3 all zero: index 0 matches, 31 mismatch.
        load_ramp();
        for (int i = 0; i < M; i++) stim[3][i] = '0;
        drive_run("zero_f3", 1'b0, 1'b0, 1'b0);

        // Reset mid-run after a mismatch has been counted.
        load_ramp();
        stim[1][2] = 12'h0FF;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int f = 0; f < 2; f++) begin
            for (int i = 0; i < M; i++) begin
                if (f == 1 && i == 10) break;
                s_if.data_valid = 1'b1;
                s_if.data       = stim[f][i];
                tick();
            end
        end
        s_if.data_valid = 1'b0;
        check("pre_rst_count", mismatch_count, 1);
        check("pre_rst_busy", busy, 1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_pass", pass, 0);
        check("mid_rst_count", mismatch_count, 0);
        check("mid_rst_bad_index", first_bad_index, 0);
        check("mid_rst_bad_frame", first_bad_frame, 0);
        check("mid_rst_rd_data", rd_data, 0);
        tick();
        load_ramp();
        drive_run("after_rst", 1'b0, 1'b0, 1'b0);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
